// File: rtl/dco_pkg.sv
// dco_pkg: shared types and helpers for the dco_nco oscillator.
//   state_t    : band-switch FSM states
//   FINE_MID   : mid-scale fine code for the default fine width
//   COARSE_MID : mid-scale coarse band for the default coarse width
//   fcw_clamp  : limits a signed FCW to [1, 2^(acc_w-1)]
package dco_pkg;

    localparam int DEF_ACC_W    = 24;
    localparam int DEF_FINE_W   = 8;
    localparam int DEF_COARSE_W = 3;

    localparam int FINE_MID   = 1 << (DEF_FINE_W - 1);
    localparam int COARSE_MID = 1 << (DEF_COARSE_W - 1);

    typedef enum logic [1:0] {
        RUN,
        SWITCH,
        SETTLE
    } state_t;

    // Upper bound is the Nyquist rate; lower bound keeps the accumulator moving.
    function automatic longint fcw_clamp(input longint raw, input int acc_w);
        longint hi;
        hi = longint'(1) << (acc_w - 1);
        if (raw < 1)
            return 1;
        else if (raw > hi)
            return hi;
        else
            return raw;
    endfunction

endpackage

// File: rtl/dco_nco_if.sv
// dco_nco_if: control and output bundle of the oscillator.
//   en          : accumulator enable
//   dfine       : fine control code (unsigned)
//   dcoarse     : requested coarse band
//   coarse_load : one-cycle band-switch request
//   osc         : oscillator output (accumulator MSB)
//   fcw         : current frequency control word
//   busy        : band switch / settle in progress
// master = loop filter side, slave = oscillator.
interface dco_nco_if #(
    parameter int ACC_W    = 24,
    parameter int FINE_W   = 8,
    parameter int COARSE_W = 3
);
    logic                en;
    logic [FINE_W-1:0]   dfine;
    logic [COARSE_W-1:0] dcoarse;
    logic                coarse_load;
    logic                osc;
    logic [ACC_W-1:0]    fcw;
    logic                busy;

    modport master (
        output en, dfine, dcoarse, coarse_load,
        input  osc, fcw, busy
    );

    modport slave (
        input  en, dfine, dcoarse, coarse_load,
        output osc, fcw, busy
    );
endinterface

// File: rtl/dco_fine_filter.sv
// dco_fine_filter: first-order IIR smoothing of the fine code.
//   clk, rst_n : clock, async active-low reset
//   run        : update the filter this cycle
//   recentre   : force the state back to mid-scale (has priority over run)
//   dfine      : fine code target
//   fi         : integer part of the filter state
// State F carries FILT_SHIFT fraction bits. Each update moves F by (T-F)/2^FILT_SHIFT,
// with a minimum step of one LSB so that F lands exactly on the target.
module dco_fine_filter #(
    parameter int FINE_W     = 8,
    parameter int FILT_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              recentre,
    input  logic [FINE_W-1:0] dfine,
    output logic [FINE_W-1:0] fi
);
    localparam int F_W = FINE_W + FILT_SHIFT;
    localparam int D_W = F_W + 1;
    localparam logic [F_W-1:0] F_MID = F_W'(1) << (F_W - 1);

    logic [F_W-1:0]        f;
    logic [F_W-1:0]        t;
    logic [F_W-1:0]        f_sum;
    logic signed [D_W-1:0] d;
    logic signed [D_W-1:0] s;

    assign t = {dfine, {FILT_SHIFT{1'b0}}};

    always_comb begin
        d = $signed({1'b0, t}) - $signed({1'b0, f});
        s = d >>> FILT_SHIFT;
        // Small positive errors shift to zero; nudge by one LSB instead.
        if (d != '0 && s == '0)
            s = d[D_W-1] ? '1 : {{(D_W-1){1'b0}}, 1'b1};
        f_sum = f + s[F_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            f <= F_MID;
        else if (recentre)
            f <= F_MID;
        else if (run)
            f <= f_sum;
    end

    assign fi = f[F_W-1:FILT_SHIFT];

endmodule

// File: rtl/dco_nco.sv
// dco_nco: numerically-controlled digital oscillator with coarse band switching.
//   clk, rst_n : system clock, async active-low reset
//   bus        : dco_nco_if slave (en, dfine, dcoarse, coarse_load -> osc, fcw, busy)
//
// state  | meaning
// RUN    | filter tracks dfine, band-switch requests accepted
// SWITCH | new band applied, fine filter re-centred, settle timer loaded
// SETTLE | filter frozen while the timer counts down to zero
module dco_nco
    import dco_pkg::*;
#(
    parameter int ACC_W         = DEF_ACC_W,
    parameter int FINE_W        = DEF_FINE_W,
    parameter int COARSE_W      = DEF_COARSE_W,
    parameter int CENTER_FCW    = 'h100000,
    parameter int FINE_GAIN     = 256,
    parameter int COARSE_STEP   = 65536,
    parameter int FILT_SHIFT    = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    dco_nco_if.slave bus
);
    localparam int CNT_W      = $clog2(SETTLE_CYCLES + 1);
    localparam int FINE_C     = 1 << (FINE_W - 1);
    localparam int COARSE_C   = 1 << (COARSE_W - 1);
    localparam logic [COARSE_W-1:0] COARSE_RST = COARSE_W'(COARSE_C);
    localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(SETTLE_CYCLES - 1);

    state_t              state;
    logic [COARSE_W-1:0] coarse;
    logic [COARSE_W-1:0] coarse_cap;
    logic [CNT_W-1:0]    cnt;
    logic [FINE_W-1:0]   fi;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [ACC_W-1:0]    fcw_next;
    logic                filt_run;
    logic                filt_recentre;
    longint              raw;

    assign filt_run      = (state == RUN);
    assign filt_recentre = (state == SWITCH);

    dco_fine_filter #(
        .FINE_W     (FINE_W),
        .FILT_SHIFT (FILT_SHIFT)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (filt_run),
        .recentre (filt_recentre),
        .dfine    (bus.dfine),
        .fi       (fi)
    );

    always_comb begin
        raw = longint'(CENTER_FCW)
            + (longint'(coarse) - longint'(COARSE_C)) * longint'(COARSE_STEP)
            + (longint'(fi) - longint'(FINE_C)) * longint'(FINE_GAIN);
        fcw_next = ACC_W'(fcw_clamp(raw, ACC_W));
    end

    assign acc_next = acc + bus.fcw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            coarse     <= COARSE_RST;
            coarse_cap <= COARSE_RST;
            cnt        <= '0;
            bus.busy   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // Requests for the band already in use are ignored.
                    if (bus.coarse_load && bus.dcoarse != coarse) begin
                        coarse_cap <= bus.dcoarse;
                        state      <= SWITCH;
                        bus.busy   <= 1'b1;
                    end
                end
                SWITCH: begin
                    coarse <= coarse_cap;
                    cnt    <= CNT_LOAD;
                    state  <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state    <= RUN;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state    <= RUN;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            bus.osc <= 1'b0;
            bus.fcw <= ACC_W'(CENTER_FCW);
        end else begin
            bus.fcw <= fcw_next;
            if (bus.en) begin
                acc     <= acc_next;
                bus.osc <= acc_next[ACC_W-1];
            end else begin
                acc     <= '0;
                bus.osc <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dco_nco.sv
// tb_dco_nco: self-checking bench for dco_nco.
// Three instances: default centre, low centre (lower clamp), high centre (Nyquist clamp).
// The default instance is compared every cycle against a behavioural model.
module tb_dco_nco;
    import dco_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dco_nco_if a0 ();
    dco_nco_if a1 ();
    dco_nco_if a2 ();

    dco_nco u0 (.clk(clk), .rst_n(rst_n), .bus(a0));
    dco_nco #(.CENTER_FCW('h10000))  u1 (.clk(clk), .rst_n(rst_n), .bus(a1));
    dco_nco #(.CENTER_FCW('h7F0000)) u2 (.clk(clk), .rst_n(rst_n), .bus(a2));

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp)
            pass_cnt++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model of the default instance ----------------
    localparam longint C0 = 'h100000;
    longint m_acc, m_fcw, m_f;
    int     m_coarse, m_pend, m_busy_left;
    logic   m_osc, m_busy;

    function automatic longint ref_clamp(input longint r);
        if (r < 1) return 1;
        if (r > 'h800000) return 'h800000;
        return r;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_osc = 0; m_busy = 0; m_busy_left = 0;
        m_coarse = COARSE_MID; m_pend = COARSE_MID;
        m_f = FINE_MID * 16; m_fcw = C0;
    endtask

    // busy_left counts the busy cycles still to come: 17 = switch cycle, 16..1 = settling.
    task automatic model_step();
        longint nf, d, s;
        nf = ref_clamp(C0 + longint'(m_coarse - COARSE_MID) * 65536
                          + (m_f / 16 - FINE_MID) * 256);
        if (a0.en) begin
            m_acc = (m_acc + m_fcw) % (longint'(1) << 24);
            m_osc = m_acc[23];
        end else begin
            m_acc = 0;
            m_osc = 0;
        end
        m_fcw = nf;
        if (m_busy_left == 0) begin
            d = longint'(a0.dfine) * 16 - m_f;
            s = (d >= 0) ? d / 16 : -((-d + 15) / 16);
            if (d != 0 && s == 0) s = (d > 0) ? 1 : -1;
            m_f = m_f + s;
            if (a0.coarse_load && int'(a0.dcoarse) != m_coarse) begin
                m_pend = a0.dcoarse;
                m_busy_left = 17;
            end
        end else if (m_busy_left == 17) begin
            m_coarse = m_pend;
            m_f = FINE_MID * 16;
            m_busy_left = 16;
        end else begin
            m_busy_left = m_busy_left - 1;
        end
        m_busy = (m_busy_left > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_osc",  a0.osc,  m_osc);
        check("model_fcw",  a0.fcw,  m_fcw);
        check("model_busy", a0.busy, m_busy);
    endtask

    typedef struct {
        logic [7:0] dfine;
        longint     fcw;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int     busy_n;
        int     viol;
        longint prev;
        logic   prev_osc;

        vecs[0] = '{8'd0,   64'hF8000};
        vecs[1] = '{8'd255, 64'h107F00};
        vecs[2] = '{8'd64,  64'hFC000};
        vecs[3] = '{8'd128, 64'h100000};

        a0.en = 1; a0.dfine = 8'd128; a0.dcoarse = 3'd4; a0.coarse_load = 0;
        a1.en = 1; a1.dfine = 8'd0;   a1.dcoarse = 3'd4; a1.coarse_load = 0;
        a2.en = 1; a2.dfine = 8'd255; a2.dcoarse = 3'd4; a2.coarse_load = 0;
        model_reset();

        #12;
        check("rst_osc",  a0.osc,  0);
        check("rst_busy", a0.busy, 0);
        check("rst_fcw",  a0.fcw,  'h100000);
        check("rst_fcw1", a1.fcw,  'h10000);
        check("rst_fcw2", a2.fcw,  'h7F0000);
        rst_n = 1'b1;

        // OSC high on enabled edges 8..15, 24..31, ...
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("osc_wave", a0.osc, (k / 8) % 2);
        end

        foreach (vecs[i]) begin
            a0.dfine = vecs[i].dfine;
            repeat (150) tick();
            check("tbl_fcw",  a0.fcw,  vecs[i].fcw);
            check("tbl_busy", a0.busy, 0);
        end

        // Step 128 -> 192: monotonic, no overshoot
        a0.dfine = 8'd192;
        prev = a0.fcw;
        viol = 0;
        repeat (150) begin
            tick();
            if (a0.fcw < prev || a0.fcw > 'h104000) viol++;
            if (a0.busy) viol++;
            prev = a0.fcw;
        end
        check("step_viol", viol, 0);
        check("step_fcw", a0.fcw, 'h104000);

        a0.dfine = 8'd128;
        repeat (150) tick();

        // Band switch to 6 with dfine scrambled during settle
        a0.dcoarse = 3'd6; a0.coarse_load = 1;
        tick();
        a0.coarse_load = 0;
        check("sw_busy_rise", a0.busy, 1);
        busy_n = int'(a0.busy);
        for (int i = 1; i <= 16; i++) begin
            a0.dfine = 8'($urandom);
            tick();
            busy_n += int'(a0.busy);
            if (i >= 2) check("settle_fcw", a0.fcw, 'h120000);
        end
        a0.dfine = 8'd128;
        tick();
        busy_n += int'(a0.busy);
        check("busy_fall", a0.busy, 0);
        check("busy_len", busy_n, 17);
        check("post_settle_fcw", a0.fcw, 'h120000);
        a0.dfine = 8'd200;
        repeat (150) tick();
        check("track_fcw", a0.fcw, 'h124800);

        // Load of the current band is ignored
        a0.dcoarse = 3'd6; a0.coarse_load = 1;
        tick();
        a0.coarse_load = 0;
        check("same_busy", a0.busy, 0);
        repeat (3) tick();
        check("same_busy2", a0.busy, 0);
        check("same_fcw", a0.fcw, 'h124800);

        // Second load mid-settle is dropped
        busy_n = 0;
        a0.dcoarse = 3'd2; a0.coarse_load = 1;
        tick();
        a0.coarse_load = 0;
        busy_n += int'(a0.busy);
        repeat (5) begin tick(); busy_n += int'(a0.busy); end
        a0.dcoarse = 3'd7; a0.coarse_load = 1;
        tick();
        a0.coarse_load = 0;
        busy_n += int'(a0.busy);
        repeat (14) begin tick(); busy_n += int'(a0.busy); end
        check("nested_busy_len", busy_n, 17);
        repeat (150) tick();
        check("nested_fcw", a0.fcw, 'hE4800);

        // Clamp corners on the low and high centre instances
        a1.dcoarse = 3'd0; a1.coarse_load = 1;
        a2.dcoarse = 3'd7; a2.coarse_load = 1;
        tick();
        a1.coarse_load = 0; a2.coarse_load = 0;
        repeat (170) tick();
        check("clamp_lo", a1.fcw, 1);
        check("clamp_hi", a2.fcw, 'h800000);
        for (int i = 0; i < 8; i++) begin
            prev_osc = a2.osc;
            tick();
            check("nyq_toggle", a2.osc, !prev_osc);
        end

        // Asynchronous reset in the middle of settling
        a0.dcoarse = 3'd5; a0.coarse_load = 1;
        tick();
        a0.coarse_load = 0;
        repeat (5) tick();
        check("pre_rst_busy", a0.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", a0.busy, 0);
        check("async_osc",  a0.osc,  0);
        check("async_fcw",  a0.fcw,  'h100000);
        model_reset();
        rst_n = 1'b1;
        a0.dfine = 8'd128; a0.dcoarse = 3'd6; a0.coarse_load = 1;
        tick();
        a0.coarse_load = 0;
        check("rerun_busy", a0.busy, 1);
        repeat (20) tick();
        check("rerun_busy_done", a0.busy, 0);
        check("rerun_fcw", a0.fcw, 'h120000);

        // Randomised traffic against the model
        repeat (600) begin
            a0.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) a0.dfine = 8'($urandom);
            a0.coarse_load = ($urandom_range(0, 19) == 0);
            a0.dcoarse = 3'($urandom);
            tick();
        end
        a0.coarse_load = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dco_nco.md
Name: dco_nco

Overview:
Synthesizable, parametrised successor to the behavioural oscillator model. It is a numerically-controlled digital oscillator with a wide fine control code, a coarse band code, and a first-order IIR smoothing filter on the fine code. A band-switch FSM with a settle window is included. It sits in the PLL between the digital loop filter (DFINE/DCOARSE source) and the divider/phase detector (OSC sink). It runs from one system clock; OSC is the accumulator MSB.

Parameters:
ACC_W, 24, phase accumulator width.
FINE_W, 8, fine control code width.
COARSE_W, 3, coarse band code width.
CENTER_FCW, 24'h100000, frequency control word at mid fine and mid coarse (fclk/16).
FINE_GAIN, 256, FCW LSBs per fine code step.
COARSE_STEP, 65536, FCW LSBs per coarse code step.
FILT_SHIFT, 4, IIR coefficient 2^-FILT_SHIFT.
SETTLE_CYCLES, 16, cycles BUSY stays high after a band switch.

Ports:
CLK  input  1  system clock, rising edge.
nRST  input  1  asynchronous active-low reset.
EN  input  1  accumulator enable.
DFINE  input  FINE_W  fine control code, unsigned.
DCOARSE  input  COARSE_W  requested coarse band, unsigned.
COARSE_LOAD  input  1  single-cycle strobe that requests a band switch to DCOARSE.
OSC  output  1  oscillator output, registered accumulator MSB.
FCW  output  ACC_W  current frequency control word, registered.
BUSY  output  1  high during SWITCH/SETTLE.

Behaviour:
- Reset (async, nRST=0):
  - ACC=0, OSC=0, BUSY=0.
  - coarse register = 2^(COARSE_W-1).
  - filter state F = 2^(FINE_W-1) << FILT_SHIFT.
  - FCW = CENTER_FCW.
  - FSM = RUN.
- Filter:
  - F is unsigned, FINE_W+FILT_SHIFT bits. Target T = DFINE << FILT_SHIFT.
  - Per cycle in RUN: D = T - F, signed, FINE_W+FILT_SHIFT+1 bits; S = D >>> FILT_SHIFT (arithmetic).
  - If D != 0 and S == 0, then S = sign(D)·1. This guarantees exact convergence.
  - F <= F + S.
  - Fine integer code FI = F >> FILT_SHIFT. F is monotonic toward T and never overshoots.
- FCW (registered, 1-cycle latency after F/coarse update):
  - raw = CENTER_FCW + (coarse - 2^(COARSE_W-1))·COARSE_STEP + (FI - 2^(FINE_W-1))·FINE_GAIN, signed, ACC_W+2 bits.
  - Clamp raw to [1, 2^(ACC_W-1)] (Nyquist limit; never zero/stall).
- Accumulator:
  - EN=1: ACC <= ACC + FCW, mod 2^ACC_W; OSC <= next ACC[ACC_W-1].
  - EN=0: ACC <= 0, OSC <= 0 from next edge. Filter and FSM keep running.
- FSM states RUN, SWITCH, SETTLE:
  - RUN: on COARSE_LOAD with DCOARSE != coarse, go to SWITCH. If DCOARSE == coarse, the strobe is ignored and the FSM stays in RUN.
  - SWITCH (1 cycle):
    - coarse <= captured DCOARSE.
    - F <= 2^(FINE_W-1) << FILT_SHIFT (re-centre fine).
    - Settle counter <= SETTLE_CYCLES-1.
    - BUSY=1. Go to SETTLE.
  - SETTLE:
    - F frozen; DFINE ignored.
    - Counter decrements each cycle. At 0, go to RUN; BUSY falls on the RUN cycle.
  - BUSY high for exactly SETTLE_CYCLES+1 cycles.
  - COARSE_LOAD during SWITCH/SETTLE is dropped.
- DCOARSE is sampled only on the COARSE_LOAD cycle. DFINE is sampled every RUN cycle.
- A COARSE_LOAD on the same cycle as a DFINE change: the switch wins; the filter re-centres in SWITCH and tracks the new DFINE after SETTLE.
- Reset mid-operation (any state) restores all reset values immediately. No partial switch survives.

Decomposition:
- Package dco_pkg:
  - state enum {RUN, SWITCH, SETTLE}.
  - function fcw_clamp.
  - localparams FINE_MID and COARSE_MID, derived from the widths.
- Sub-module dco_fine_filter:
  - Contains the IIR state, the ±1 convergence rule, and the freeze/recentre inputs.
  - Outputs FI.
- Top level holds the FSM, the FCW adder/clamp and the accumulator.

Test Plan:
- Defaults, nRST released, EN=1, DFINE=128, no load → FCW=0x100000; OSC first rises on the 8th enabled edge, then period 16 cycles, 50% duty.
- DFINE 128→192 at steady state → FI non-decreasing, reaches exactly 192 with no overshoot; FCW settles at 0x104000; BUSY stays 0.
- COARSE_LOAD with DCOARSE=6, DFINE=128 → BUSY high 17 cycles; FCW=0x120000 during settle; F held at mid despite DFINE toggling; after RUN, FI tracks DFINE.
- COARSE_LOAD with DCOARSE=4 (current) → BUSY stays 0; FCW unchanged. Second COARSE_LOAD issued mid-SETTLE → ignored; coarse keeps the first value.
- Clamp cases:
  - CENTER_FCW=0x10000, DCOARSE=0 loaded, DFINE=0 converged → FCW=1.
  - CENTER_FCW=0x7F0000, DCOARSE=7, DFINE=255 → FCW=0x800000; OSC toggles every cycle.
- nRST asserted mid-SETTLE (asynchronously, between edges) → BUSY, OSC drop to 0 immediately; FCW=0x100000; after release, FSM is in RUN and responds to a new COARSE_LOAD.
